// File: rtl/keypad_event_scanner.sv
// Keypad matrix scanner with debounce and a key-event FIFO.
//
// Strobes one column at a time and senses the rows. A press must stay stable
// for DEB_CNT scan ticks before its code is queued, and a release must stay
// stable just as long before scanning resumes. Presses that light more than
// one row (ghosting) are tracked but never queued.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   key_row    raw row sense, active-high, asynchronous to clk
//   key_col    column strobe, one-hot, all-zero until the first scan tick
//   key_code   event code at the FIFO head (row*N_COL + col + 1), 0 when empty
//   key_valid  FIFO not empty
//   key_ready  consumer accept; pops when key_valid && key_ready
//   key_held   a key is currently accepted as pressed
//   overflow   sticky flag: an event was dropped because the FIFO was full
//   ovf_clr    synchronous clear of overflow (a new overflow wins)
module keypad_event_scanner #(
   parameter int N_COL      = 3,
   parameter int N_ROW      = 4,
   parameter int SCAN_DIV   = 12500,
   parameter int DEB_CNT    = 4,
   parameter int FIFO_DEPTH = 4,
   localparam int CW        = $clog2(N_COL * N_ROW + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_ROW-1:0] key_row,
   output logic [N_COL-1:0] key_col,
   output logic [CW-1:0]    key_code,
   output logic             key_valid,
   input  logic             key_ready,
   output logic             key_held,
   output logic             overflow,
   input  logic             ovf_clr
);

   localparam int DW   = $clog2(SCAN_DIV);
   localparam int CNTW = $clog2(DEB_CNT + 1);
   localparam int AW   = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {StScan, StDebP, StHeld, StDebR} state_e;

   // Row synchronizer
   logic [N_ROW-1:0] row_m, row_s;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_m <= '0;
         row_s <= '0;
      end else begin
         row_m <= key_row;
         row_s <= row_m;
      end
   end

   // Scan tick divider
   logic [DW-1:0] div_q;
   logic          tick;

   assign tick = (div_q == DW'(SCAN_DIV - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q <= '0;
      end else begin
         div_q <= tick ? '0 : div_q + DW'(1);
      end
   end

   // Scan / debounce FSM
   state_e           state_q, state_d;
   logic [N_COL-1:0] col_q, col_d, col_next;
   logic [N_ROW-1:0] cap_q, cap_d;
   logic [CNTW-1:0]  cnt_q, cnt_d, cnt_inc;
   logic             cnt_done;
   logic             push;
   logic [CW-1:0]    ev_code;
   int               ridx, cidx;

   // From the all-zero reset value the first advance lands on col0.
   assign col_next = (col_q == '0) ? N_COL'(1) : ((col_q << 1) | (col_q >> (N_COL - 1)));
   assign cnt_inc  = cnt_q + CNTW'(1);
   assign cnt_done = (cnt_inc == CNTW'(DEB_CNT));

   // Code is only pushed for a one-hot row, so the highest set bit is the row.
   always_comb begin
      ridx = 0;
      cidx = 0;
      for (int r = 0; r < N_ROW; r++) begin
         if (row_s[r]) ridx = r;
      end
      for (int c = 0; c < N_COL; c++) begin
         if (col_q[c]) cidx = c;
      end
      ev_code = CW'(ridx * N_COL + cidx + 1);
   end

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      cap_d   = cap_q;
      cnt_d   = cnt_q;
      push    = 1'b0;
      if (tick) begin
         unique case (state_q)
            StScan: begin
               if (row_s != '0 && col_q != '0) begin
                  cap_d = row_s;
                  cnt_d = CNTW'(1);
                  if (DEB_CNT == 1) begin
                     push    = $onehot(row_s);
                     state_d = StHeld;
                  end else begin
                     state_d = StDebP;
                  end
               end else begin
                  col_d = col_next;
               end
            end
            StDebP: begin
               if (row_s != cap_q) begin
                  state_d = StScan;
                  col_d   = col_next;
               end else begin
                  cnt_d = cnt_inc;
                  if (cnt_done) begin
                     push    = $onehot(row_s);
                     state_d = StHeld;
                  end
               end
            end
            StHeld: begin
               if (row_s == '0) begin
                  cnt_d = CNTW'(1);
                  if (DEB_CNT == 1) begin
                     state_d = StScan;
                     col_d   = col_next;
                  end else begin
                     state_d = StDebR;
                  end
               end
            end
            StDebR: begin
               if (row_s != '0) begin
                  state_d = StHeld;
               end else begin
                  cnt_d = cnt_inc;
                  if (cnt_done) begin
                     state_d = StScan;
                     col_d   = col_next;
                  end
               end
            end
            default: state_d = StScan;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StScan;
         col_q   <= '0;
         cap_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         cap_q   <= cap_d;
         cnt_q   <= cnt_d;
      end
   end

   assign key_col  = col_q;
   assign key_held = (state_q == StHeld) || (state_q == StDebR);

   // Event FIFO; pointers carry an extra wrap bit to tell full from empty.
   logic [CW-1:0] mem [FIFO_DEPTH];
   logic [AW:0]   wr_q, rd_q;
   logic          full, pop, do_push, ovf_set;
   logic          ovf_q;

   assign key_valid = (wr_q != rd_q);
   assign full      = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign pop       = key_valid && key_ready;
   assign do_push   = push && (!full || pop);
   assign ovf_set   = push && full && !pop;
   assign key_code  = key_valid ? mem[rd_q[AW-1:0]] : '0;
   assign overflow  = ovf_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         ovf_q <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_q[AW-1:0]] <= ev_code;
            wr_q              <= wr_q + 1'b1;
         end
         if (pop) rd_q <= rd_q + 1'b1;
         ovf_q <= ovf_set | (ovf_q & ~ovf_clr);
      end
   end

endmodule

// File: tb/tb_keypad_event_scanner.sv
// Self-checking bench for keypad_event_scanner. A small key-matrix model turns
// pressed keys into row sense from the strobed column; expected event codes go
// into a scoreboard queue when a key is pressed and are compared as the
// consumer pops them.
module tb_keypad_event_scanner;

   localparam int N_COL = 3;
   localparam int N_ROW = 4;
   localparam int SCAN_DIV = 4;
   localparam int DEB_CNT = 3;
   localparam int FIFO_DEPTH = 2;
   localparam int CW = $clog2(N_COL * N_ROW + 1);

   logic             clk;
   logic             rst;
   logic [N_ROW-1:0] key_row;
   logic [N_COL-1:0] key_col;
   logic [CW-1:0]    key_code;
   logic             key_valid;
   logic             key_ready;
   logic             key_held;
   logic             overflow;
   logic             ovf_clr;

   logic [N_COL*N_ROW-1:0] keys;
   logic [CW-1:0]          sb[$];
   int                     checks = 0;
   int                     errors = 0;
   int                     pops = 0;
   int                     pops_before;
   logic [1:0]             tdiv;

   typedef struct {
      int         r;
      int         c;
      logic [3:0] code;
      logic [2:0] col;
      logic [2:0] col_after;
   } vec_t;
   vec_t tbl[4];

   keypad_event_scanner #(
      .N_COL(N_COL), .N_ROW(N_ROW), .SCAN_DIV(SCAN_DIV), .DEB_CNT(DEB_CNT),
      .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk(clk), .rst(rst), .key_row(key_row), .key_col(key_col), .key_code(key_code),
      .key_valid(key_valid), .key_ready(key_ready), .key_held(key_held),
      .overflow(overflow), .ovf_clr(ovf_clr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Key matrix: a pressed key at (r,c) shorts row r to column c.
   always_comb begin
      key_row = '0;
      for (int r = 0; r < N_ROW; r++) begin
         for (int c = 0; c < N_COL; c++) begin
            if (keys[r*N_COL+c] && key_col[c]) key_row[r] = 1'b1;
         end
      end
   end

   // Bench time reference: posedge after tdiv==3 is a scan tick.
   always @(posedge clk or posedge rst) begin
      if (rst) tdiv <= 2'd0;
      else tdiv <= tdiv + 2'd1;
   end

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endfunction

   // Consumer side of the scoreboard.
   always @(negedge clk) begin
      if (!rst && key_valid && key_ready) begin
         pops++;
         if (sb.size() == 0) begin
            check("unexpected_event", {28'd0, key_code}, 32'd0);
         end else begin
            check("event_code", {28'd0, key_code}, {28'd0, sb.pop_front()});
         end
      end
   end

   task automatic wait_tick();
      do @(negedge clk); while (tdiv != 2'd3);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_held(logic val, string name);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (key_held !== val && n < 300);
      check(name, {31'd0, key_held}, {31'd0, val});
   endtask

   task automatic set_key(int r, int c, logic v);
      keys[r*N_COL+c] = v;
   endtask

   // Press, wait for acceptance, release, wait for release to be accepted.
   task automatic tap(int r, int c, logic [2:0] col, logic [2:0] col_after);
      set_key(r, c, 1'b1);
      wait_held(1'b1, "tap_held");
      check("tap_col_frozen", {29'd0, key_col}, {29'd0, col});
      set_key(r, c, 1'b0);
      wait_held(1'b0, "tap_release");
      check("tap_col_after", {29'd0, key_col}, {29'd0, col_after});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{0, 0, 4'd1, 3'b001, 3'b010};
      tbl[1] = '{3, 2, 4'd12, 3'b100, 3'b001};
      tbl[2] = '{2, 1, 4'd8, 3'b010, 3'b100};
      tbl[3] = '{1, 2, 4'd6, 3'b100, 3'b001};

      rst = 1'b0;
      keys = '0;
      key_ready = 1'b0;
      ovf_clr = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("rst_key_col", {29'd0, key_col}, 32'd0);
      check("rst_key_valid", {31'd0, key_valid}, 32'd0);
      check("rst_key_code", {28'd0, key_code}, 32'd0);
      check("rst_key_held", {31'd0, key_held}, 32'd0);
      check("rst_overflow", {31'd0, overflow}, 32'd0);
      repeat (2) @(posedge clk);

      // Key (1,1) pressed; only senses once col1 is strobed.
      set_key(1, 1, 1'b1);
      sb.push_back(4'd5);
      @(negedge clk) rst = 1'b0;
      wait_tick();
      check("first_tick_col0", {29'd0, key_col}, 32'd1);
      wait_tick();
      check("t2_col1", {29'd0, key_col}, 32'd2);
      wait_tick();
      check("capture_col_frozen", {29'd0, key_col}, 32'd2);
      check("capture_not_held", {31'd0, key_held}, 32'd0);
      wait_tick();
      check("deb_no_valid_yet", {31'd0, key_valid}, 32'd0);
      wait_tick();
      check("accept_valid", {31'd0, key_valid}, 32'd1);
      check("accept_code", {28'd0, key_code}, 32'd5);
      check("accept_held", {31'd0, key_held}, 32'd1);
      check("accept_col", {29'd0, key_col}, 32'd2);
      key_ready = 1'b1;
      set_key(1, 1, 1'b0);
      wait_tick();
      wait_tick();
      check("deb_r_still_held", {31'd0, key_held}, 32'd1);
      wait_tick();
      check("release_held", {31'd0, key_held}, 32'd0);
      check("release_col_adv", {29'd0, key_col}, 32'd4);

      // Bounce on (0,2): two ticks then gone.
      set_key(0, 2, 1'b1);
      wait_tick();
      check("bounce_col_a", {29'd0, key_col}, 32'd4);
      wait_tick();
      check("bounce_col_b", {29'd0, key_col}, 32'd4);
      set_key(0, 2, 1'b0);
      wait_tick();
      check("bounce_col_resume", {29'd0, key_col}, 32'd1);
      check("bounce_no_event", {31'd0, key_valid}, 32'd0);
      check("bounce_not_held", {31'd0, key_held}, 32'd0);

      // Table of single presses with a ready consumer.
      for (int i = 0; i < 4; i++) begin
         sb.push_back(tbl[i].code);
         tap(tbl[i].r, tbl[i].c, tbl[i].col, tbl[i].col_after);
      end
      repeat (3) @(negedge clk);
      check("table_sb_drained", sb.size(), 32'd0);

      // Three presses with no consumer: third is dropped.
      @(posedge clk);
      #1 key_ready = 1'b0;
      pops_before = pops;
      sb.push_back(4'd1);
      sb.push_back(4'd2);
      tap(0, 0, 3'b001, 3'b010);
      tap(0, 1, 3'b010, 3'b100);
      check("full_no_ovf", {31'd0, overflow}, 32'd0);
      ovf_clr = 1'b1;
      set_key(0, 2, 1'b1);
      wait_held(1'b1, "third_held");
      check("ovf_set_wins", {31'd0, overflow}, 32'd1);
      ovf_clr = 1'b0;
      set_key(0, 2, 1'b0);
      wait_held(1'b0, "third_release");
      check("ovf_sticky", {31'd0, overflow}, 32'd1);
      check("fifo_head", {28'd0, key_code}, 32'd1);
      check("fifo_valid", {31'd0, key_valid}, 32'd1);
      @(posedge clk);
      #1 key_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("drain_valid_low", {31'd0, key_valid}, 32'd0);
      check("drain_pops", pops - pops_before, 32'd2);

      // Ghost press on col0 rows 0 and 2.
      set_key(0, 0, 1'b1);
      set_key(2, 0, 1'b1);
      wait_held(1'b1, "ghost_held");
      check("ghost_col", {29'd0, key_col}, 32'd1);
      check("ghost_no_event", {31'd0, key_valid}, 32'd0);
      set_key(0, 0, 1'b0);
      set_key(2, 0, 1'b0);
      wait_held(1'b0, "ghost_release");
      check("ghost_no_event_after", {31'd0, key_valid}, 32'd0);
      @(posedge clk);
      #1 ovf_clr = 1'b1;
      @(posedge clk);
      #1 ovf_clr = 1'b0;
      check("ovf_cleared", {31'd0, overflow}, 32'd0);

      // Long hold gives exactly one event.
      pops_before = pops;
      sb.push_back(4'd7);
      set_key(2, 0, 1'b1);
      wait_held(1'b1, "long_held");
      repeat (20) wait_tick();
      check("long_still_held", {31'd0, key_held}, 32'd1);
      set_key(2, 0, 1'b0);
      wait_held(1'b0, "long_release");
      repeat (3) @(negedge clk);
      check("long_one_event", pops - pops_before, 32'd1);

      // Reset while debouncing with one entry queued.
      @(posedge clk);
      #1 key_ready = 1'b0;
      tap(1, 0, 3'b001, 3'b010);
      set_key(0, 1, 1'b1);
      wait_tick();
      check("pre_rst_queued", {31'd0, key_valid}, 32'd1);
      check("pre_rst_deb_col", {29'd0, key_col}, 32'd2);
      check("pre_rst_not_held", {31'd0, key_held}, 32'd0);
      #1 rst = 1'b1;
      #1;
      check("mid_rst_valid", {31'd0, key_valid}, 32'd0);
      check("mid_rst_col", {29'd0, key_col}, 32'd0);
      check("mid_rst_held", {31'd0, key_held}, 32'd0);
      keys = '0;
      @(negedge clk) rst = 1'b0;
      wait_tick();
      check("post_rst_col0", {29'd0, key_col}, 32'd1);
      check("post_rst_empty", {31'd0, key_valid}, 32'd0);
      check("sb_empty_end", sb.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
